// File: rtl/mx_operand_stage_pkg.sv
// Shared definitions for the ALU operand-B select stage: select codes and
// select-width derivation.
package mx_operand_stage_pkg;

  typedef enum int unsigned {
    SEL_RB       = 0,
    SEL_SEXT     = 1,
    SEL_ZEXT     = 2,
    SEL_UPPER    = 3,
    SEL_FWD_BASE = 4
  } sel_code_e;

  // Select width covering the four fixed sources plus every forwarding port.
  function automatic int unsigned sel_w(input int unsigned num_fwd);
    return $clog2(int'(SEL_FWD_BASE) + int'(num_fwd));
  endfunction

endpackage

// File: rtl/mx_operand_stage_if.sv
// Operand-stage bus: upstream operand sources and select, downstream
// registered operand handshake.
interface mx_operand_stage_if
  import mx_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned NUM_FWD = 2
) ();

  localparam int unsigned SEL_W = sel_w(NUM_FWD);

  logic [DATA_W-1:0]         in_RB;
  logic [IMM_W-1:0]          in_IMM;
  logic [NUM_FWD*DATA_W-1:0] in_FWD;
  logic [SEL_W-1:0]          S_MXB;
  logic                      in_valid;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic                      flush;
  logic [DATA_W-1:0]         out;
  logic                      err;

  modport master (
    output in_RB, in_IMM, in_FWD, S_MXB, in_valid, out_ready, flush,
    input  in_ready, out_valid, out, err
  );

  modport slave (
    input  in_RB, in_IMM, in_FWD, S_MXB, in_valid, out_ready, flush,
    output in_ready, out_valid, out, err
  );

endinterface

// File: rtl/mx_operand_sel.sv
// Combinational operand source decode with immediate extension; flags any
// select code outside the populated range.
module mx_operand_sel
  import mx_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned SEL_W   = sel_w(NUM_FWD)
) (
  input  logic [DATA_W-1:0]         rb,
  input  logic [IMM_W-1:0]          imm,
  input  logic [NUM_FWD*DATA_W-1:0] fwd,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         value,
  output logic                      invalid
);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_upper;
  int unsigned       sel_i;

  // Casts degrade to identity when IMM_W == DATA_W, so all three immediate
  // forms collapse to the raw field without a special case.
  assign imm_sext  = DATA_W'($signed(imm));
  assign imm_zext  = DATA_W'(imm);
  assign imm_upper = imm_zext << (DATA_W - IMM_W);
  assign sel_i     = 32'(sel);

  always_comb begin
    value   = '0;
    invalid = 1'b0;
    if (sel_i == SEL_RB) begin
      value = rb;
    end else if (sel_i == SEL_SEXT) begin
      value = imm_sext;
    end else if (sel_i == SEL_ZEXT) begin
      value = imm_zext;
    end else if (sel_i == SEL_UPPER) begin
      value = imm_upper;
    end else if (sel_i >= SEL_FWD_BASE + NUM_FWD) begin
      invalid = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
        if (sel_i == SEL_FWD_BASE + k) value = fwd[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mx_operand_stage.sv
// Registered ALU operand-B stage: source select, single-entry output register
// with valid/ready handshake, flush, and sticky select-error flag.
module mx_operand_stage
  import mx_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mx_operand_stage_if.slave  bus
);

  localparam int unsigned SEL_W = sel_w(NUM_FWD);

  logic [DATA_W-1:0] sel_value;
  logic              sel_invalid;
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;
  logic              err_q;
  logic              in_ready;
  logic              accept;

  mx_operand_sel #(
    .DATA_W  (DATA_W),
    .IMM_W   (IMM_W),
    .NUM_FWD (NUM_FWD),
    .SEL_W   (SEL_W)
  ) u_sel (
    .rb      (bus.in_RB),
    .imm     (bus.in_IMM),
    .fwd     (bus.in_FWD),
    .sel     (bus.S_MXB),
    .value   (sel_value),
    .invalid (sel_invalid)
  );

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Flush beats accept; data is only written on accept so it holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= sel_value;
      out_valid_q <= 1'b1;
      if (sel_invalid) err_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mx_operand_stage.sv
// Directed bench for mx_operand_stage with hand-computed expected values.
module tb_mx_operand_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mx_operand_stage_if #(.DATA_W(32), .IMM_W(16), .NUM_FWD(2)) bus ();

  mx_operand_stage #(.DATA_W(32), .IMM_W(16), .NUM_FWD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and new inputs driven 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stall_rb [3] = '{32'h1111_1111, 32'h2222_3333, 32'h0BAD_F00D};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.S_MXB     = 3'd0;
    bus.in_RB     = 32'hFFFF_0000;
    bus.in_IMM    = 16'h0000;
    bus.in_FWD    = '0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;

    // 1. reset then first transfer
    step();
    step();
    check("rst_out", bus.out, 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    rst_n = 1'b1;
    step();
    check("first_out", bus.out, 32'hFFFF_0000);
    check("first_valid", 32'(bus.out_valid), 32'h1);

    // 2. extensions and forwarding, back-to-back
    bus.in_IMM = 16'h8001;
    bus.in_FWD = {32'h2222_2222, 32'h1111_1111};
    bus.S_MXB = 3'd1; step(); check("sext", bus.out, 32'hFFFF_8001);
    bus.S_MXB = 3'd2; step(); check("zext", bus.out, 32'h0000_8001);
    bus.S_MXB = 3'd3; step(); check("upper", bus.out, 32'h8001_0000);
    bus.S_MXB = 3'd4; step(); check("fwd0", bus.out, 32'h1111_1111);
    bus.S_MXB = 3'd5; step(); check("fwd1", bus.out, 32'h2222_2222);
    check("b2b_valid", 32'(bus.out_valid), 32'h1);

    // 3. stall
    bus.S_MXB = 3'd0;
    bus.in_RB = 32'hA5A5_A5A5;
    step();
    check("stall_load", bus.out, 32'hA5A5_A5A5);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_RB = stall_rb[i];
      #1;
      check("stall_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      check("stall_hold", bus.out, 32'hA5A5_A5A5);
      check("stall_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    check("release_out", bus.out, 32'h0BAD_F00D);
    check("release_valid", 32'(bus.out_valid), 32'h1);

    // 4. flush while holding a valid operand
    bus.flush = 1'b1;
    bus.in_RB = 32'h1234_5678;
    step();
    check("flush_valid", 32'(bus.out_valid), 32'h0);
    check("flush_out", bus.out, 32'h0BAD_F00D);
    bus.flush = 1'b0;
    bus.in_RB = 32'hCAFE_F00D;
    step();
    check("refill_out", bus.out, 32'hCAFE_F00D);
    bus.in_valid = 1'b0;
    step();
    check("drain_valid", 32'(bus.out_valid), 32'h0);
    check("drain_out", bus.out, 32'hCAFE_F00D);

    // 6. flushed invalid select leaves err clear
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    bus.S_MXB = 3'd6;
    step();
    check("flinv_err", 32'(bus.err), 32'h0);
    check("flinv_valid", 32'(bus.out_valid), 32'h0);
    bus.flush = 1'b0;

    // 5. invalid select is sticky
    bus.S_MXB = 3'd7;
    step();
    check("inv_out", bus.out, 32'h0);
    check("inv_valid", 32'(bus.out_valid), 32'h1);
    check("inv_err", 32'(bus.err), 32'h1);
    bus.S_MXB = 3'd0;
    for (int i = 0; i < 10; i++) begin
      bus.in_RB = 32'h100 + 32'(i);
      step();
      check("sticky_out", bus.out, 32'h100 + 32'(i));
      check("sticky_err", 32'(bus.err), 32'h1);
    end

    // reset mid-stall drops the held operand and clears err
    bus.out_ready = 1'b0;
    bus.in_RB = 32'hDEAD_BEEF;
    step();
    check("pre_rst_hold", bus.out, 32'h109);
    rst_n = 1'b0;
    step();
    check("midrst_out", bus.out, 32'h0);
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_err", 32'(bus.err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
